// File: rtl/conbus_pkg.sv
// Shared Wishbone bus definitions: width helper, CTI cycle-type encodings
// and the arbiter state encoding.
package conbus_pkg;

  // Ceiling log2, never less than 1, so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/conbus_rr_arb_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
interface conbus_rr_arb_if #(
  parameter int N_MASTERS = 5
);
  localparam int IDX_W = conbus_pkg::clog2(N_MASTERS);

  logic [N_MASTERS-1:0] m_cyc_i;
  logic                 ack_i;
  logic [N_MASTERS-1:0] gnt_o;
  logic [IDX_W-1:0]     gnt_idx_o;
  logic                 gnt_valid_o;
  logic [N_MASTERS-1:0] err_o;

  modport master (
    output m_cyc_i, ack_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, err_o
  );

  modport slave (
    input  m_cyc_i, ack_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, err_o
  );
endinterface

// File: rtl/conbus_rr_pick.sv
// Rotating-priority search: first unmasked requester above ptr, wrapping.
module conbus_rr_pick #(
  parameter int N_MASTERS = 5,
  parameter int IDX_W     = 3
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] mask,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     index
);
  logic [N_MASTERS-1:0] eligible;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_elig
    assign eligible[gi] = req[gi] & ~mask[gi];
  end

  // Walk from farthest to nearest so the nearest hit above ptr is kept last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_MASTERS);
      if (eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
endmodule

// File: rtl/conbus_rr_arb.sv
// Round-robin Wishbone bus arbiter with non-split bursts and a bus watchdog
// that aborts a stalled master and masks it until it drops cyc.
module conbus_rr_arb
  import conbus_pkg::*;
#(
  parameter int N_MASTERS = 5,
  parameter int TIMEOUT   = 256
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  conbus_rr_arb_if.slave   bus
);
  localparam int IDX_W = clog2(N_MASTERS);
  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e           state_reg, state_next;
  logic [N_MASTERS-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 valid_reg, valid_next;
  logic [N_MASTERS-1:0] err_reg, err_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [N_MASTERS-1:0] mask_reg, mask_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic                 armed_reg;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 do_grant;

  conbus_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (bus.m_cyc_i),
    .mask  (mask_reg),
    .ptr   (ptr_reg),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    err_next   = '0;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    mask_next  = mask_reg & bus.m_cyc_i;
    do_grant   = 1'b0;

    case (state_reg)
      ST_IDLE: do_grant = armed_reg && pick_found;
      ST_GRANT: begin
        // Release is checked before the watchdog so a master that lets go
        // on the timeout cycle is never flagged.
        if (!bus.m_cyc_i[idx_reg]) begin
          if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = '0;
            idx_next   = '0;
            valid_next = 1'b0;
            cnt_next   = '0;
          end
        end else if (TIMEOUT != 0 && cnt_reg == CNT_MAX) begin
          state_next         = ST_ABORT;
          err_next[idx_reg]  = 1'b1;
          mask_next[idx_reg] = 1'b1;
          gnt_next           = '0;
          idx_next           = '0;
          valid_next         = 1'b0;
          cnt_next           = '0;
        end else if (TIMEOUT != 0) begin
          cnt_next = bus.ack_i ? '0 : cnt_reg + 1'b1;
        end
      end
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (do_grant) begin
      state_next         = ST_GRANT;
      gnt_next           = '0;
      gnt_next[pick_idx] = 1'b1;
      idx_next           = pick_idx;
      valid_next         = 1'b1;
      ptr_next           = pick_idx;
      cnt_next           = '0;
    end
  end

  // armed_reg holds off arbitration for the first edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= '0;
      cnt_reg   <= '0;
      mask_reg  <= '0;
      ptr_reg   <= PTR_RST;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      mask_reg  <= mask_next;
      ptr_reg   <= ptr_next;
      armed_reg <= 1'b1;
    end
  end

  assign bus.gnt_o       = gnt_reg;
  assign bus.gnt_idx_o   = idx_reg;
  assign bus.gnt_valid_o = valid_reg;
  assign bus.err_o       = err_reg;
endmodule

// File: tb/tb_conbus_rr_arb.sv
// Directed bench for conbus_rr_arb (5 masters, watchdog 8) with an event
// scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_conbus_rr_arb;
  localparam int N = 5;

  typedef struct {
    bit           is_err;
    logic [N-1:0] vec;
    int           idx;
  } ev_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [N-1:0] prev_gnt = '0;

  always #5 sys_clk = ~sys_clk;

  conbus_rr_arb_if #(.N_MASTERS(N)) bus ();

  conbus_rr_arb #(
    .N_MASTERS (N),
    .TIMEOUT   (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_grant(input int i);
    ev_t e;
    e.is_err = 1'b0;
    e.vec    = '0;
    e.vec[i] = 1'b1;
    e.idx    = i;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int i);
    ev_t e;
    e.is_err = 1'b1;
    e.vec    = '0;
    e.vec[i] = 1'b1;
    e.idx    = i;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every new grant and every error pulse consumes one expected event.
  always @(negedge sys_clk) begin : monitor
    ev_t e;
    if (sys_rst_n) begin
      if (bus.gnt_o != '0 && bus.gnt_o != prev_gnt) begin
        $display("%0t grant vec=%b idx=%0d", $time, bus.gnt_o, bus.gnt_idx_o);
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 32'(bus.gnt_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_vec", 32'(bus.gnt_o), e.is_err ? 32'd0 : 32'(e.vec));
          check("grant_idx", 32'(bus.gnt_idx_o), 32'(e.idx));
          check("grant_valid", 32'(bus.gnt_valid_o), 32'd1);
        end
      end
      if (bus.err_o != '0) begin
        $display("%0t error vec=%b", $time, bus.err_o);
        if (exp_q.size() == 0) begin
          check("err_unexpected", 32'(bus.err_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_vec", 32'(bus.err_o), e.is_err ? 32'(e.vec) : 32'd0);
        end
      end
    end
    prev_gnt <= bus.gnt_o;
  end

  initial begin
    int held[N];
    int grants_seen;
    int gap;
    int n;
    int bad;
    logic [N-1:0] last;

    bus.m_cyc_i = '0;
    bus.ack_i   = 1'b0;
    #2 sys_rst_n = 1'b0;
    tick(2);
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_idx", 32'(bus.gnt_idx_o), 32'd0);
    check("rst_valid", 32'(bus.gnt_valid_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);

    // All masters request; each drops cyc after 3 granted cycles.
    bus.m_cyc_i = '1;
    for (int i = 0; i < N; i++) push_grant(i);
    push_grant(0);
    sys_rst_n = 1'b1;
    tick(1);
    check("first_edge_no_grant", 32'(bus.gnt_valid_o), 32'd0);
    for (int i = 0; i < N; i++) held[i] = 0;
    grants_seen = 0;
    gap = 0;
    last = '0;
    for (int c = 0; c < 80 && grants_seen < 6; c++) begin
      tick(1);
      if (bus.gnt_o != '0 && bus.gnt_o != last) grants_seen++;
      if (grants_seen > 0 && !bus.gnt_valid_o) gap = 1;
      last = bus.gnt_o;
      for (int i = 0; i < N; i++) begin
        if (!bus.m_cyc_i[i]) begin
          bus.m_cyc_i[i] = 1'b1;
        end else if (bus.gnt_o[i]) begin
          held[i]++;
          if (held[i] == 3) begin
            bus.m_cyc_i[i] = 1'b0;
            held[i] = 0;
          end
        end
      end
    end
    bus.m_cyc_i = '0;
    check("rr_grants_seen", 32'(grants_seen), 32'd6);
    check("rr_no_gap", 32'(gap), 32'd0);
    tick(2);
    check("rr_idle", 32'(bus.gnt_valid_o), 32'd0);

    // Lone requester, master 2.
    bus.m_cyc_i = 5'b00100;
    push_grant(2);
    tick(1);
    check("single_latency_gnt", 32'(bus.gnt_o), 32'h04);
    check("single_latency_idx", 32'(bus.gnt_idx_o), 32'd2);
    tick(3);
    bus.m_cyc_i = '0;
    tick(2);
    check("single_idle_valid", 32'(bus.gnt_valid_o), 32'd0);
    check("single_idle_gnt", 32'(bus.gnt_o), 32'd0);

    // Master 1 stalls without ack; master 3 waits behind it.
    bus.m_cyc_i = 5'b00010;
    push_grant(1);
    tick(1);
    check("to_gnt1", 32'(bus.gnt_o), 32'h02);
    bus.m_cyc_i = 5'b01010;
    push_err(1);
    push_grant(3);
    n = 0;
    while (bus.err_o == '0 && n < 30) begin
      tick(1);
      n++;
    end
    check("to_err_delay", 32'(n), 32'd9);
    check("to_err_vec", 32'(bus.err_o), 32'h02);
    check("to_err_gnt_clear", 32'(bus.gnt_o), 32'd0);
    tick(1);
    check("to_err_pulse_len", 32'(bus.err_o), 32'd0);
    tick(1);
    check("to_next_gnt", 32'(bus.gnt_o), 32'h08);
    tick(2);
    bus.m_cyc_i = 5'b00010;
    tick(3);
    check("to_masked_no_regrant", 32'(bus.gnt_valid_o), 32'd0);
    bus.m_cyc_i = '0;
    tick(1);
    bus.m_cyc_i = 5'b00010;
    push_grant(1);
    tick(1);
    check("to_regrant_after_drop", 32'(bus.gnt_o), 32'h02);

    // Same grant kept alive by an ack every 7 cycles.
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      bus.ack_i = (k % 7 == 6);
      tick(1);
      if (bus.gnt_o != 5'b00010 || bus.err_o != '0) bad = 1;
    end
    bus.ack_i = 1'b0;
    check("ack_hold_no_err", 32'(bad), 32'd0);
    bus.m_cyc_i = '0;
    tick(2);

    // Release on the very cycle the counter reaches the limit.
    bus.m_cyc_i = 5'b10100;
    push_grant(2);
    push_grant(4);
    tick(1);
    tick(8);
    bus.m_cyc_i = 5'b10000;
    tick(1);
    check("race_no_err", 32'(bus.err_o), 32'd0);
    check("race_handoff", 32'(bus.gnt_o), 32'h10);
    bus.m_cyc_i = '0;
    tick(2);

    // Reset mid-grant to master 3.
    bus.m_cyc_i = 5'b01000;
    push_grant(3);
    tick(3);
    #3 sys_rst_n = 1'b0;
    #1;
    check("rst_async_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_async_valid", 32'(bus.gnt_valid_o), 32'd0);
    check("rst_async_idx", 32'(bus.gnt_idx_o), 32'd0);
    bus.m_cyc_i = 5'b01001;
    tick(1);
    sys_rst_n = 1'b1;
    push_grant(0);
    tick(1);
    check("post_rst_first_edge", 32'(bus.gnt_valid_o), 32'd0);
    tick(1);
    check("post_rst_gnt0", 32'(bus.gnt_o), 32'h01);
    bus.m_cyc_i = '0;
    tick(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
